cpu_exec_ctrl: RTL and testbench

- Sequencer on the control side of the execution stage's `i_en_exec` / `o_exec_done` handshake.
- Accepts one decoded instruction at a time and pulses/holds the execution enable until execution is done.
- Performs the optional data-memory transaction, writes the register file, and commits the next program counter from the exec stage's PC-select and branch outputs.
- Sits between decode and exec in the multi-cycle (non-pipelined) core configuration.

---
 rtl/cpu_exec_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_cpu_exec_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_exec_ctrl.sv
// cpu_exec_ctrl
// Control-side sequencer for the multi-cycle (non-pipelined) core. It takes one
// decoded instruction at a time and enables the exec stage until exec reports
// done. It then runs the optional data-memory transaction, writes the register
// file and commits the next program counter.
//
// Handshake semantics: a transfer on a valid/ready pair happens on a rising
// clock edge where both are high. o_en_exec/i_exec_done behaves the same way:
// o_en_exec stays high until i_exec_done is sampled high. o_dmem_req and its
// address/data/we stay stable until i_dmem_ack is sampled high. Read data is
// valid in the ack cycle.
//
// Ports:
//   i_clk, i_rst                 clock, async active-high reset
//   i_instr_valid/o_instr_ready  instruction handshake from decode
//   i_rd_addr, i_sel_wb,         decoded fields, latched on accept
//   i_mem_rd, i_mem_wr, i_imm
//   o_en_exec, i_exec_done       exec-stage enable / result valid
//   i_sel_pc, i_branch_taken     next-PC select and taken flag from exec
//   i_alu_out, i_adder_out,      exec-stage results, latched on done
//   i_muldiv_out, i_rf_rd2_data
//   o_dmem_*, i_dmem_*           data memory request channel
//   o_rf_wr_*                    register file write port
//   o_pc, o_retired, o_trap      architectural PC, retire pulse, sticky trap
//   o_dbg_state                  current FSM state, for observation only
//
// Encodings:
//   sel_wb: 0 alu, 1 muldiv, 2 pc+4, 3 dmem
//   sel_pc: 0 pc+4, 1 pc+imm, 2 alu (adder_out with bit 0 cleared)
module cpu_exec_ctrl #(
    parameter logic [31:0] p_boot_addr       = 32'h0000_0000,
    parameter int unsigned p_rf_read_buf     = 0,
    parameter int unsigned p_trap_misaligned = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_instr_valid,
    output logic        o_instr_ready,
    input  logic [4:0]  i_rd_addr,
    input  logic [1:0]  i_sel_wb,
    input  logic        i_mem_rd,
    input  logic        i_mem_wr,
    input  logic [31:0] i_imm,
    output logic        o_en_exec,
    input  logic        i_exec_done,
    input  logic [1:0]  i_sel_pc,
    input  logic        i_branch_taken,
    input  logic [31:0] i_alu_out,
    input  logic [31:0] i_adder_out,
    input  logic [31:0] i_muldiv_out,
    input  logic [31:0] i_rf_rd2_data,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wr_data,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rd_data,
    output logic        o_rf_wr_en,
    output logic [4:0]  o_rf_wr_addr,
    output logic [31:0] o_rf_wr_data,
    output logic [31:0] o_pc,
    output logic        o_retired,
    output logic        o_trap,
    output logic [2:0]  o_dbg_state
);

    localparam logic [1:0] WB_ALU    = 2'd0;
    localparam logic [1:0] WB_MULDIV = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;
    localparam logic [1:0] WB_DMEM   = 2'd3;

    localparam logic [1:0] PC_PLUS_4 = 2'd0;
    localparam logic [1:0] PC_IMM    = 2'd1;
    localparam logic [1:0] PC_ALU    = 2'd2;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] READ = 3'd1;
    localparam logic [2:0] EXEC = 3'd2;
    localparam logic [2:0] MEM  = 3'd3;
    localparam logic [2:0] WB   = 3'd4;
    localparam logic [2:0] TRAP = 3'd5;

    logic [2:0]  state;
    logic [31:0] pc_q;
    logic [4:0]  rd_q;
    logic [1:0]  sel_wb_q;
    logic        mem_rd_q;
    logic        mem_wr_q;
    logic [31:0] imm_q;
    logic [31:0] target_q;
    logic [31:0] alu_q;
    logic [31:0] muldiv_q;
    logic [31:0] adder_q;
    logic [31:0] rd2_q;
    logic [31:0] load_q;

    logic [31:0] pc_plus_4;
    logic [31:0] target_next;
    logic        misaligned;
    logic [31:0] wb_data;

    assign pc_plus_4 = pc_q + 32'd4;

    // Target is formed from the exec outputs in the done cycle, so the exec
    // stage does not need to hold sel_pc/taken after done.
    always_comb begin
        target_next = pc_plus_4;
        case (i_sel_pc)
            PC_PLUS_4: target_next = pc_plus_4;
            PC_IMM:    target_next = pc_q + imm_q;
            PC_ALU:    target_next = {i_adder_out[31:1], 1'b0};
            default:   target_next = pc_plus_4;
        endcase
    end

    assign misaligned = (p_trap_misaligned != 0) && i_branch_taken &&
                        (target_next[1:0] != 2'b00);

    always_comb begin
        wb_data = alu_q;
        case (sel_wb_q)
            WB_ALU:    wb_data = alu_q;
            WB_MULDIV: wb_data = muldiv_q;
            WB_PC:     wb_data = pc_plus_4;
            WB_DMEM:   wb_data = load_q;
            default:   wb_data = alu_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            pc_q     <= p_boot_addr;
            rd_q     <= '0;
            sel_wb_q <= WB_ALU;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            imm_q    <= '0;
            target_q <= '0;
            alu_q    <= '0;
            muldiv_q <= '0;
            adder_q  <= '0;
            rd2_q    <= '0;
            load_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_instr_valid) begin
                        rd_q     <= i_rd_addr;
                        sel_wb_q <= i_sel_wb;
                        mem_rd_q <= i_mem_rd;
                        mem_wr_q <= i_mem_wr;
                        imm_q    <= i_imm;
                        state    <= (p_rf_read_buf != 0) ? READ : EXEC;
                    end
                end
                READ: state <= EXEC;
                EXEC: begin
                    if (i_exec_done) begin
                        alu_q    <= i_alu_out;
                        muldiv_q <= i_muldiv_out;
                        adder_q  <= i_adder_out;
                        rd2_q    <= i_rf_rd2_data;
                        target_q <= target_next;
                        if (misaligned)
                            state <= TRAP;
                        else if (mem_rd_q || mem_wr_q)
                            state <= MEM;
                        else
                            state <= WB;
                    end
                end
                MEM: begin
                    if (i_dmem_ack) begin
                        if (mem_rd_q)
                            load_q <= i_dmem_rd_data;
                        state <= WB;
                    end
                end
                WB: begin
                    pc_q  <= target_q;
                    state <= IDLE;
                end
                TRAP: state <= TRAP;
                default: state <= IDLE;
            endcase
        end
    end

    // All outputs decode from reset-cleared state, so they clear the moment
    // reset asserts (an in-flight dmem request drops immediately).
    assign o_instr_ready  = (state == IDLE);
    assign o_en_exec      = (state == EXEC);
    assign o_dmem_req     = (state == MEM);
    assign o_dmem_we      = (state == MEM) && mem_wr_q;
    assign o_dmem_addr    = adder_q;
    assign o_dmem_wr_data = rd2_q;
    assign o_rf_wr_en     = (state == WB) && (rd_q != 5'd0) && !mem_wr_q;
    assign o_rf_wr_addr   = rd_q;
    assign o_rf_wr_data   = wb_data;
    assign o_pc           = pc_q;
    assign o_retired      = (state == WB);
    assign o_trap         = (state == TRAP);
    assign o_dbg_state    = state;

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
module tb_cpu_exec_ctrl;

  localparam logic [31:0] BOOT = 32'h0000_0100;

  localparam logic [1:0] WB_ALU    = 2'd0;
  localparam logic [1:0] WB_MULDIV = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;
  localparam logic [1:0] WB_DMEM   = 2'd3;
  localparam logic [1:0] PC_P4     = 2'd0;
  localparam logic [1:0] PC_IMM    = 2'd1;
  localparam logic [1:0] PC_ALU    = 2'd2;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_instr_valid = 1'b0;
  logic        o_instr_ready;
  logic [4:0]  i_rd_addr = '0;
  logic [1:0]  i_sel_wb = '0;
  logic        i_mem_rd = 1'b0;
  logic        i_mem_wr = 1'b0;
  logic [31:0] i_imm = '0;
  logic        o_en_exec;
  logic        i_exec_done = 1'b0;
  logic [1:0]  i_sel_pc = '0;
  logic        i_branch_taken = 1'b0;
  logic [31:0] i_alu_out = '0;
  logic [31:0] i_adder_out = '0;
  logic [31:0] i_muldiv_out = '0;
  logic [31:0] i_rf_rd2_data = '0;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [31:0] o_dmem_wr_data;
  logic        i_dmem_ack = 1'b0;
  logic [31:0] i_dmem_rd_data = '0;
  logic        o_rf_wr_en;
  logic [4:0]  o_rf_wr_addr;
  logic [31:0] o_rf_wr_data;
  logic [31:0] o_pc;
  logic        o_retired;
  logic        o_trap;
  logic [2:0]  dbg_state;

  cpu_exec_ctrl #(
    .p_boot_addr(BOOT),
    .p_rf_read_buf(0),
    .p_trap_misaligned(1)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_instr_valid(i_instr_valid), .o_instr_ready(o_instr_ready),
    .i_rd_addr(i_rd_addr), .i_sel_wb(i_sel_wb),
    .i_mem_rd(i_mem_rd), .i_mem_wr(i_mem_wr), .i_imm(i_imm),
    .o_en_exec(o_en_exec), .i_exec_done(i_exec_done),
    .i_sel_pc(i_sel_pc), .i_branch_taken(i_branch_taken),
    .i_alu_out(i_alu_out), .i_adder_out(i_adder_out),
    .i_muldiv_out(i_muldiv_out), .i_rf_rd2_data(i_rf_rd2_data),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
    .o_dmem_addr(o_dmem_addr), .o_dmem_wr_data(o_dmem_wr_data),
    .i_dmem_ack(i_dmem_ack), .i_dmem_rd_data(i_dmem_rd_data),
    .o_rf_wr_en(o_rf_wr_en), .o_rf_wr_addr(o_rf_wr_addr),
    .o_rf_wr_data(o_rf_wr_data), .o_pc(o_pc),
    .o_retired(o_retired), .o_trap(o_trap),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters and check ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] f_target(input logic [31:0] pc, input logic [1:0] sel_pc,
                                           input logic [31:0] imm, input logic [31:0] adder);
    if (sel_pc == PC_IMM) return pc + imm;
    if (sel_pc == PC_ALU) return adder & 32'hFFFF_FFFE;
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] f_wb(input logic [1:0] sel_wb, input logic [31:0] pc,
                                       input logic [31:0] alu, input logic [31:0] muldiv,
                                       input logic [31:0] load);
    if (sel_wb == WB_MULDIV) return muldiv;
    if (sel_wb == WB_PC) return pc + 32'd4;
    if (sel_wb == WB_DMEM) return load;
    return alu;
  endfunction

  logic [36:0] exp_q[$];     // expected register writes {addr, data}
  logic [31:0] pc_q[$];      // expected committed PCs, in order
  logic [31:0] model_pc = BOOT;
  logic        trap_exp = 1'b0;
  logic        run = 1'b0;

  // ---------------- scoreboard / compare process ----------------
  logic [31:0] cur_pc = BOOT;
  logic        retire_seen = 1'b0;
  logic [36:0] e;

  always @(negedge i_clk) begin
    if (i_rst) begin
      cur_pc = BOOT;
      retire_seen = 1'b0;
    end else if (run) begin
      if (retire_seen) begin
        retire_seen = 1'b0;
        if (pc_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL retire: unexpected retirement, pc now %h", o_pc);
        end else begin
          cur_pc = pc_q.pop_front();
        end
      end
      check("pc", o_pc, cur_pc);
      check("trap", {31'd0, o_trap}, {31'd0, trap_exp});
      if (o_rf_wr_en) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rf_write: unexpected write x%0d = %h", o_rf_wr_addr, o_rf_wr_data);
        end else begin
          e = exp_q.pop_front();
          check("rf_wr_addr", {27'd0, o_rf_wr_addr}, {27'd0, e[36:32]});
          check("rf_wr_data", o_rf_wr_data, e[31:0]);
        end
      end
      if (o_retired) retire_seen = 1'b1;
    end
  end

  // ---------------- driver ----------------
  logic        last_wr_en;
  logic [31:0] last_wr_data;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // One instruction: accept, exec for exec_cycles, optional MEM with ack in
  // MEM cycle ack_delay, WB. rst_at > 0 asserts reset in that MEM cycle.
  task automatic issue(input logic [4:0] rd, input logic [1:0] sel_wb,
                       input logic mem_rd, input logic mem_wr, input logic [31:0] imm,
                       input logic [1:0] sel_pc, input logic taken,
                       input logic [31:0] alu, input logic [31:0] adder,
                       input logic [31:0] muldiv, input logic [31:0] rd2,
                       input int exec_cycles, input int ack_delay,
                       input logic [31:0] rd_data, input int rst_at);
    logic [31:0] tgt;
    logic [31:0] wbd;
    logic        trap;
    int          en_cnt;
    int          rdy_cnt;
    int          req_cnt;
    tgt  = f_target(model_pc, sel_pc, imm, adder);
    trap = taken && (tgt[1:0] != 2'b00);
    wbd  = f_wb(sel_wb, model_pc, alu, muldiv, rd_data);
    if (rd != 5'd0 && !mem_wr && !trap) exp_q.push_back({rd, wbd});
    if (!trap) pc_q.push_back(tgt);
    last_wr_en = 1'b0;
    last_wr_data = '0;

    check("accept_ready", {31'd0, o_instr_ready}, 32'd1);
    i_rd_addr = rd; i_sel_wb = sel_wb; i_mem_rd = mem_rd; i_mem_wr = mem_wr; i_imm = imm;
    i_sel_pc = sel_pc; i_branch_taken = taken;
    i_alu_out = alu; i_adder_out = adder; i_muldiv_out = muldiv; i_rf_rd2_data = rd2;
    i_instr_valid = 1'b1;
    tick();
    i_instr_valid = 1'b0;

    en_cnt = 0;
    rdy_cnt = 0;
    for (int c = 1; c <= exec_cycles; c++) begin
      // A second instruction offered during a long exec must be ignored.
      if (c < exec_cycles && exec_cycles > 1) begin
        i_instr_valid = 1'b1;
        i_rd_addr = 5'd31;
      end else begin
        i_instr_valid = 1'b0;
      end
      i_exec_done = (c == exec_cycles);
      if (o_en_exec) en_cnt++;
      if (o_instr_ready) rdy_cnt++;
      tick();
    end
    i_exec_done = 1'b0;
    i_instr_valid = 1'b0;
    check("en_exec_cycles", en_cnt, exec_cycles);
    check("ready_low_in_exec", rdy_cnt, 0);
    check("en_exec_drop", {31'd0, o_en_exec}, 32'd0);

    if (trap) begin
      trap_exp = 1'b1;
      return;
    end

    if (mem_rd || mem_wr) begin
      req_cnt = 0;
      for (int d = 1; d <= ack_delay; d++) begin
        if (d == rst_at) begin
          i_rst = 1'b1;
          #1;
          check("rst_mem_req", {31'd0, o_dmem_req}, 32'd0);
          check("rst_mem_pc", o_pc, BOOT);
          exp_q.delete();
          pc_q.delete();
          model_pc = BOOT;
          trap_exp = 1'b0;
          i_dmem_ack = 1'b1;   // late ack during reset is ignored
          tick();
          i_dmem_ack = 1'b0;
          tick();
          i_rst = 1'b0;
          tick();
          check("rst_ready", {31'd0, o_instr_ready}, 32'd1);
          return;
        end
        if (o_dmem_req && o_dmem_addr == adder && o_dmem_we == mem_wr &&
            (!mem_wr || o_dmem_wr_data == rd2))
          req_cnt++;
        i_dmem_ack = (d == ack_delay);
        i_dmem_rd_data = rd_data;
        tick();
      end
      i_dmem_ack = 1'b0;
      i_dmem_rd_data = '0;
      check("dmem_req_cycles", req_cnt, ack_delay);
    end

    check("retired", {31'd0, o_retired}, 32'd1);
    last_wr_en = o_rf_wr_en;
    last_wr_data = o_rf_wr_data;
    tick();
    check("retired_pulse", {31'd0, o_retired}, 32'd0);
    check("ready_after", {31'd0, o_instr_ready}, 32'd1);
    model_pc = tgt;
  endtask

  // ---------------- stimulus ----------------
  int trap_cnt;
  int rdy_cnt2;

  initial begin
    #3 i_rst = 1'b1;
    #1;
    check("rst_async_ready", {31'd0, o_instr_ready}, 32'd1);
    check("rst_async_pc", o_pc, BOOT);
    repeat (2) tick();
    i_rst = 1'b0;
    tick();
    check("rst_en_exec", {31'd0, o_en_exec}, 32'd0);
    check("rst_dmem_req", {31'd0, o_dmem_req}, 32'd0);
    check("rst_dmem_we", {31'd0, o_dmem_we}, 32'd0);
    check("rst_dmem_addr", o_dmem_addr, 32'd0);
    check("rst_dmem_wr_data", o_dmem_wr_data, 32'd0);
    check("rst_rf_wr_en", {31'd0, o_rf_wr_en}, 32'd0);
    check("rst_rf_wr_addr", {27'd0, o_rf_wr_addr}, 32'd0);
    check("rst_rf_wr_data", o_rf_wr_data, 32'd0);
    check("rst_retired", {31'd0, o_retired}, 32'd0);
    check("rst_trap", {31'd0, o_trap}, 32'd0);
    run = 1'b1;

    // ADD x5 = 0x1234 at pc 0x100
    issue(5'd5, WB_ALU, 0, 0, 32'd0, PC_P4, 0, 32'h1234, 32'd0, 32'd0, 32'd0, 1, 0, 32'd0, 0);
    check("add_wr_en", {31'd0, last_wr_en}, 32'd1);
    check("add_wr_data", last_wr_data, 32'h1234);
    check("add_pc", o_pc, 32'h104);

    // jump to 0
    issue(5'd0, WB_ALU, 0, 0, 32'd0, PC_ALU, 1, 32'd0, 32'd0, 32'd0, 32'd0, 1, 0, 32'd0, 0);
    check("jmp0_pc", o_pc, 32'h0);

    // BEQ taken, imm -8 at pc 0 wraps
    issue(5'd0, WB_ALU, 0, 0, 32'hFFFF_FFF8, PC_IMM, 1, 32'd1, 32'd0, 32'd0, 32'd0, 1, 0, 32'd0, 0);
    check("beq_wr_en", {31'd0, last_wr_en}, 32'd0);
    check("beq_pc", o_pc, 32'hFFFF_FFF8);

    // jump to 0x40, then JALR x1 with adder 0x203
    issue(5'd0, WB_ALU, 0, 0, 32'd0, PC_ALU, 1, 32'd0, 32'h40, 32'd0, 32'd0, 1, 0, 32'd0, 0);
    check("jmp40_pc", o_pc, 32'h40);
    issue(5'd1, WB_PC, 0, 0, 32'd0, PC_ALU, 0, 32'd0, 32'h203, 32'd0, 32'd0, 1, 0, 32'd0, 0);
    check("jalr_wr_data", last_wr_data, 32'h44);
    check("jalr_pc", o_pc, 32'h202);

    // DIV taking 34 exec cycles
    issue(5'd3, WB_MULDIV, 0, 0, 32'd0, PC_P4, 0, 32'hAAAA, 32'd0, 32'd7, 32'd0, 34, 0, 32'd0, 0);
    check("div_wr_data", last_wr_data, 32'h7);
    check("div_pc", o_pc, 32'h206);

    // LW with ack in the third MEM cycle
    issue(5'd7, WB_DMEM, 1, 0, 32'd0, PC_P4, 0, 32'h55, 32'h1000, 32'd0, 32'd0, 1, 3, 32'hDEAD_BEEF, 0);
    check("lw_wr_data", last_wr_data, 32'hDEAD_BEEF);
    check("lw_pc", o_pc, 32'h20A);

    // SW with same-cycle ack: no RF write even though rd != 0
    issue(5'd9, WB_ALU, 0, 1, 32'd0, PC_P4, 0, 32'h77, 32'h2000, 32'd0, 32'hCAFE_F00D, 1, 1, 32'd0, 0);
    check("sw_wr_en", {31'd0, last_wr_en}, 32'd0);
    check("sw_pc", o_pc, 32'h20E);

    // SW with reset in the second MEM cycle
    issue(5'd0, WB_ALU, 0, 1, 32'd0, PC_P4, 0, 32'd0, 32'h3000, 32'd0, 32'd1, 1, 5, 32'd0, 2);
    check("post_rst_pc", o_pc, BOOT);

    // JAL taken to 0x102 from pc 0x100: misaligned, sticky trap
    issue(5'd1, WB_PC, 0, 0, 32'd2, PC_IMM, 1, 32'd0, 32'd0, 32'd0, 32'd0, 1, 0, 32'd0, 0);
    i_instr_valid = 1'b1;
    i_rd_addr = 5'd2;
    i_exec_done = 1'b1;
    trap_cnt = 0;
    rdy_cnt2 = 0;
    for (int k = 0; k < 6; k++) begin
      if (o_trap) trap_cnt++;
      if (o_instr_ready) rdy_cnt2++;
      tick();
    end
    i_instr_valid = 1'b0;
    i_exec_done = 1'b0;
    check("trap_sticky_cycles", trap_cnt, 6);
    check("trap_ready_low", rdy_cnt2, 0);
    check("trap_pc", o_pc, 32'h100);
    check("trap_no_wr", {31'd0, o_rf_wr_en}, 32'd0);
    check("trap_no_exec", {31'd0, o_en_exec}, 32'd0);

    repeat (2) tick();
    check("exp_q_empty", exp_q.size(), 0);
    check("pc_q_empty", pc_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
